// File: rtl/usb_bus_pkg.sv
// usb_bus_pkg: shared types and constants for the asynchronous parallel
// memory bus initiator (usb_bus_master) and its phase timer.
//   bus_state_t    - initiator FSM state encoding
//   DEF_*          - default bus timing, in clk_usb cycles
//   REG_RDDLY_LEN  - cycles the responder keeps driving data after rd_n rises
//   TURN_MIN       - smallest read-to-write turnaround that avoids contention
package usb_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DRAIN,
    ST_TURN
  } bus_state_t;

  localparam int DEF_ADDR_WIDTH    = 21;
  localparam int DEF_SETUP_CYCLES  = 2;
  localparam int DEF_STROBE_CYCLES = 3;
  localparam int DEF_HOLD_CYCLES   = 2;
  localparam int DEF_TURN_CYCLES   = 4;

  // Shared with the responder: its read-drive extension after rd_n rises.
  localparam int REG_RDDLY_LEN = 3;
  localparam int TURN_MIN      = REG_RDDLY_LEN + 1;

  // Width of the phase timer; every phase length must fit in it.
  localparam int TMR_W = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_bus_master_if.sv
// usb_bus_master_if: command and byte-stream side of usb_bus_master.
//   cmd_*   - burst command (direction, start address, beat count)
//   wdata*  - write byte stream into the initiator
//   rdata*  - read byte stream out of the initiator
// Handshake rule for all three channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. A source holds valid and its payload
// stable until that edge; ready may change freely and never waits on valid.
//   modport master - command/stream source (testbench or host logic)
//   modport slave  - the initiator itself
interface usb_bus_master_if #(
  parameter int ADDR_WIDTH = 21
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [8:0]            cmd_len;
  logic [7:0]            wdata;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [7:0]            rdata;
  logic                  rdata_valid;
  logic                  rdata_ready;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, rdata_ready,
    input  cmd_ready, wdata_ready, rdata, rdata_valid
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, rdata_ready,
    output cmd_ready, wdata_ready, rdata, rdata_valid
  );
endinterface

// File: rtl/usb_bus_timer.sv
// usb_bus_timer: loadable down-counter timing one bus phase.
//   load/load_val - start a phase lasting load_val+1 cycles
//   done          - high on the last cycle of the phase (count == 0)
module usb_bus_timer
  import usb_bus_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_usb,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk_usb or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/usb_bus_master.sv
// usb_bus_master: initiator for an 8-bit asynchronous parallel memory bus.
// Turns single/burst commands into ce_n/rd_n/wr_n strobe waveforms with
// programmable setup, strobe, hold and read-turnaround timing.
//   clk_usb, resetn     - clock and asynchronous active-low reset
//   cmd_if (slave)      - command, write-byte and read-byte streams
//   busy                - high whenever the FSM is not in IDLE
//   addr_o, data_o,
//   data_oe, data_i     - bus address, write data + drive enable, read data
//   rd_n, wr_n, ce_n    - active-low bus strobes
//   dbg_state           - current FSM state
module usb_bus_master
  import usb_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int TURN_CYCLES   = DEF_TURN_CYCLES
) (
  input  logic                  clk_usb,
  input  logic                  resetn,
  usb_bus_master_if.slave       cmd_if,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [7:0]            data_o,
  output logic                  data_oe,
  input  logic [7:0]            data_i,
  output logic                  rd_n,
  output logic                  wr_n,
  output logic                  ce_n,
  output bus_state_t            dbg_state
);

  // Turnaround is never allowed below the responder's drive extension + 1.
  localparam int TURN_EFF = max_int(TURN_CYCLES, TURN_MIN);

  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TURN_LD   = TMR_W'(TURN_EFF - 1);

  bus_state_t       state;
  logic             write_q;
  logic [8:0]       beats_left;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;
  logic             cmd_fire;
  logic             wdata_fire;
  logic             last_beat;
  logic             rd_stall;

  assign cmd_fire   = cmd_if.cmd_valid & cmd_if.cmd_ready;
  assign wdata_fire = (state == ST_LOAD) & cmd_if.wdata_valid & cmd_if.wdata_ready;
  assign last_beat  = (beats_left == 9'd1);
  // A new read sample would overwrite a byte the consumer has not taken yet.
  assign rd_stall   = cmd_if.rdata_valid & ~cmd_if.rdata_ready;
  assign dbg_state  = state;

  usb_bus_timer #(.W(TMR_W)) u_timer (
    .clk_usb  (clk_usb),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer reload on every transition into a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire && (cmd_if.cmd_len != 9'd0) && !cmd_if.cmd_write) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_LOAD: begin
        if (wdata_fire) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (tmr_done && (write_q || !rd_stall)) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_DRAIN: begin
        if (cmd_if.rdata_ready) begin
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done && !write_q) begin
          tmr_load = 1'b1;
          tmr_val  = last_beat ? TURN_LD : SETUP_LD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_usb or negedge resetn) begin
    if (!resetn) begin
      state              <= ST_IDLE;
      write_q            <= 1'b0;
      beats_left         <= '0;
      addr_o             <= '0;
      data_o             <= '0;
      data_oe            <= 1'b0;
      rd_n               <= 1'b1;
      wr_n               <= 1'b1;
      ce_n               <= 1'b1;
      busy               <= 1'b0;
      cmd_if.cmd_ready   <= 1'b1;
      cmd_if.wdata_ready <= 1'b0;
      cmd_if.rdata       <= '0;
      cmd_if.rdata_valid <= 1'b0;
    end else begin
      if (cmd_if.rdata_valid && cmd_if.rdata_ready) cmd_if.rdata_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_fire && (cmd_if.cmd_len != 9'd0)) begin
            addr_o           <= cmd_if.cmd_addr;
            write_q          <= cmd_if.cmd_write;
            beats_left       <= cmd_if.cmd_len;
            cmd_if.cmd_ready <= 1'b0;
            busy             <= 1'b1;
            if (cmd_if.cmd_write) begin
              state              <= ST_LOAD;
              cmd_if.wdata_ready <= 1'b1;
            end else begin
              state <= ST_SETUP;
              ce_n  <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (wdata_fire) begin
            data_o             <= cmd_if.wdata;
            data_oe            <= 1'b1;
            ce_n               <= 1'b0;
            cmd_if.wdata_ready <= 1'b0;
            state              <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            state <= ST_STROBE;
            if (write_q) wr_n <= 1'b0;
            else         rd_n <= 1'b0;
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            wr_n <= 1'b1;
            rd_n <= 1'b1;
            if (!write_q && rd_stall) begin
              // Sample discarded; the strobe is repeated once the byte drains.
              state <= ST_DRAIN;
            end else begin
              state <= ST_HOLD;
              if (!write_q) begin
                cmd_if.rdata       <= data_i;
                cmd_if.rdata_valid <= 1'b1;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (cmd_if.rdata_ready) begin
            rd_n  <= 1'b0;
            state <= ST_STROBE;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            if (last_beat) begin
              ce_n    <= 1'b1;
              data_oe <= 1'b0;
              if (write_q) begin
                state            <= ST_IDLE;
                cmd_if.cmd_ready <= 1'b1;
                busy             <= 1'b0;
              end else begin
                state <= ST_TURN;
              end
            end else begin
              beats_left <= beats_left - 9'd1;
              addr_o     <= addr_o + ADDR_WIDTH'(1);
              if (write_q) begin
                state              <= ST_LOAD;
                ce_n               <= 1'b1;
                data_oe            <= 1'b0;
                cmd_if.wdata_ready <= 1'b1;
              end else begin
                state <= ST_SETUP;
              end
            end
          end
        end
        ST_TURN: begin
          if (tmr_done) begin
            state            <= ST_IDLE;
            cmd_if.cmd_ready <= 1'b1;
            busy             <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
